vx_dcache_rsp_collector: RTL and testbench
==========================================

VX_DCACHE_RSP_COLLECTOR -- requirements
Module: VX_dcache_rsp_collector

Interface
REQ-001 SHALL have parameter NUM_REQS, default 4, number of lanes.
REQ-002 SHALL have parameter WORD_SIZE, default 4, bytes per lane word; WW = WORD_SIZE*8.
REQ-003 SHALL have parameter TAG_WIDTH, default 8, response tag width.
REQ-004 SHALL have parameter NUM_ENTRIES, default 4 (power of 2, >=2), collection table depth; IDW = log2(NUM_ENTRIES).
REQ-005 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-007 SHALL have ports alloc_valid in 1, alloc_tmask in NUM_REQS, alloc_tag in TAG_WIDTH, alloc_ready out 1: open a collection entry.
REQ-008 SHALL have port alloc_id  out  IDW  entry index granted by the current alloc handshake.
REQ-009 SHALL have ports lane_rsp_valid in NUM_REQS, lane_rsp_id in NUM_REQS x IDW, lane_rsp_data in NUM_REQS x WW, lane_rsp_ready out NUM_REQS: per-lane returns.
REQ-010 SHALL have ports rsp_valid out 1, rsp_tmask out NUM_REQS, rsp_data out NUM_REQS x WW, rsp_tag out TAG_WIDTH, rsp_ready in 1: master end of the dcache response bundle.

Function
REQ-011 Each entry SHALL be in one of FREE, PENDING, DONE, holding expected mask, received mask, tag, per-lane data.
REQ-012 alloc_ready SHALL be 1 iff at least one entry is FREE in the registered state; alloc_id SHALL be the lowest-index FREE entry.
REQ-013 On alloc_valid&&alloc_ready: entry FREE->PENDING, expected=alloc_tmask, received=0, tag latched.
REQ-014 Alloc with alloc_tmask==0 SHALL move the entry FREE->DONE directly.
REQ-015 lane_rsp_ready SHALL be constant 1 for all lanes; lane i writes only column i of entry lane_rsp_id[i].
REQ-016 Lane i fire SHALL store data and set received[i] when the entry is PENDING and expected[i]=1 and received[i]=0; otherwise ignored with no state change (simulation assertion fires).
REQ-017 All lanes SHALL update the same or different entries in one cycle without conflict.
REQ-018 Entry SHALL go PENDING->DONE on the edge at which received (including that cycle's updates) equals expected.
REQ-019 Output register SHALL load when empty or when rsp_valid&&rsp_ready; source = DONE entry chosen by rotating priority starting one past the last emitted index; loaded entry goes DONE->FREE same edge.
REQ-020 While rsp_valid&&!rsp_ready, all rsp_* SHALL hold stable.
REQ-021 rsp_tmask = entry expected mask; rsp_data lanes with tmask bit 0 SHALL be zero; rsp_tag = latched tag.
REQ-022 Latency: final lane response at edge N -> DONE after N -> rsp_valid high from edge N+1, given output free.
REQ-023 Entry freed at edge N SHALL become allocatable from cycle after edge N (alloc_ready uses registered state only; no same-cycle bypass).
REQ-024 Alloc of an entry and a lane response to that same entry in the same cycle: lane response ignored (entry not yet PENDING).
REQ-025 Full table (no FREE) SHALL deassert alloc_ready; lane responses and output drain SHALL continue.

Reset
REQ-026 Asserting reset (low) SHALL asynchronously force all entries FREE, received/expected masks 0, rotating pointer 0, rsp_valid 0.
REQ-027 During reset, alloc_ready SHALL read 0; after release, alloc_ready=1 and alloc_id=0 on the first cycle.
REQ-028 Reset mid-operation SHALL discard all pending and DONE entries and any held output without emitting them.
REQ-029 rsp_tmask, rsp_data, rsp_tag SHALL reset to 0.

Verification
REQ-030 Alloc tmask=4'b1011, tag=8'h5A -> id 0; lanes 0,1,3 return 32'h11,32'h22,32'h44 in separate cycles -> one rsp, tmask 4'b1011, data {44,0,22,11}, tag 5A, 1 cycle after last lane.
REQ-031 Four allocs fill table -> alloc_ready=0; complete entry 2 with rsp_ready=1 -> entry 2 emitted, alloc_ready=1 next cycle, alloc_id=2.
REQ-032 Entries 0 and 1 DONE same cycle, rsp_ready held 0 for 5 cycles -> outputs stable with entry 0; then entry 0, then entry 1 emitted on consecutive cycles.
REQ-033 Alloc tmask=0, tag=8'h33 -> rsp_valid 1 cycle after alloc, tmask 0, data 0, tag 33.
REQ-034 Duplicate lane-2 response and response to FREE entry -> ignored, no extra rsp, assertion reported.
REQ-035 Reset low while 2 entries PENDING and rsp_valid=1 -> rsp_valid drops immediately; after release no stale rsp, alloc_id=0.

Source files
------------

// File: rtl/vx_dcache_rsp_collector.sv
// Collects per-lane dcache responses into per-request entries and emits one
// bundled response (mask, lane data, tag) per completed request, in rotating order.
module vx_dcache_rsp_collector #(
    parameter int NUM_REQS    = 4,
    parameter int WORD_SIZE   = 4,
    parameter int TAG_WIDTH   = 8,
    parameter int NUM_ENTRIES = 4,
    localparam int WW         = WORD_SIZE * 8,
    localparam int IDW        = $clog2(NUM_ENTRIES)
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic                     alloc_valid,
    input  logic [NUM_REQS-1:0]      alloc_tmask,
    input  logic [TAG_WIDTH-1:0]     alloc_tag,
    output logic                     alloc_ready,
    output logic [IDW-1:0]           alloc_id,

    input  logic [NUM_REQS-1:0]      lane_rsp_valid,
    input  logic [NUM_REQS*IDW-1:0]  lane_rsp_id,
    input  logic [NUM_REQS*WW-1:0]   lane_rsp_data,
    output logic [NUM_REQS-1:0]      lane_rsp_ready,

    output logic                     rsp_valid,
    output logic [NUM_REQS-1:0]      rsp_tmask,
    output logic [NUM_REQS*WW-1:0]   rsp_data,
    output logic [TAG_WIDTH-1:0]     rsp_tag,
    input  logic                     rsp_ready
);

    localparam logic [1:0] ST_FREE    = 2'd0;
    localparam logic [1:0] ST_PENDING = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    logic [1:0]           entry_state    [NUM_ENTRIES];
    logic [NUM_REQS-1:0]  entry_expected [NUM_ENTRIES];
    logic [NUM_REQS-1:0]  entry_received [NUM_ENTRIES];
    logic [TAG_WIDTH-1:0] entry_tag      [NUM_ENTRIES];
    logic [WW-1:0]        entry_data     [NUM_ENTRIES][NUM_REQS];
    logic [IDW-1:0]       rr_ptr;

    logic [IDW-1:0]       lane_id   [NUM_REQS];
    logic [WW-1:0]        lane_word [NUM_REQS];
    logic [NUM_REQS-1:0]  lane_accept;
    logic [NUM_REQS-1:0]  entry_hits [NUM_ENTRIES];

    logic                 any_free;
    logic [IDW-1:0]       free_id;
    logic                 alloc_fire;
    logic                 done_found;
    logic [IDW-1:0]       done_id;
    logic [IDW-1:0]       scan_id;
    logic                 out_load;
    logic                 emit_fire;
    logic [NUM_REQS*WW-1:0] sel_data;

    assign lane_rsp_ready = '1;

    always_comb begin
        for (int i = 0; i < NUM_REQS; i++) begin
            lane_id[i]   = lane_rsp_id[i*IDW +: IDW];
            lane_word[i] = lane_rsp_data[i*WW +: WW];
        end
    end

    // NOTE: every always_comb output gets a default before any conditional
    // assignment so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        any_free = 1'b0;
        free_id  = '0;
        for (int e = NUM_ENTRIES - 1; e >= 0; e--) begin
            if (entry_state[e] == ST_FREE) begin
                any_free = 1'b1;
                free_id  = e[IDW-1:0];
            end
        end
    end

    // Allocation sees only registered state; reset gating keeps it low while held in reset.
    assign alloc_ready = any_free & reset;
    assign alloc_id    = free_id;
    assign alloc_fire  = alloc_valid & alloc_ready;

    // A lane write is accepted only into a column still owed by a PENDING entry.
    always_comb begin
        lane_accept = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            lane_accept[i] = lane_rsp_valid[i]
                          && (entry_state[lane_id[i]] == ST_PENDING)
                          && entry_expected[lane_id[i]][i]
                          && !entry_received[lane_id[i]][i];
        end
    end

    always_comb begin
        for (int e = 0; e < NUM_ENTRIES; e++) begin
            entry_hits[e] = '0;
            for (int i = 0; i < NUM_REQS; i++) begin
                entry_hits[e][i] = lane_accept[i] && (lane_id[i] == e[IDW-1:0]);
            end
        end
    end

    // Rotating search for a DONE entry, starting at rr_ptr.
    always_comb begin
        done_found = 1'b0;
        done_id    = rr_ptr;
        scan_id    = '0;
        for (int k = 0; k < NUM_ENTRIES; k++) begin
            scan_id = rr_ptr + k[IDW-1:0];
            if (!done_found && entry_state[scan_id] == ST_DONE) begin
                done_found = 1'b1;
                done_id    = scan_id;
            end
        end
    end

    assign out_load  = !rsp_valid || rsp_ready;
    assign emit_fire = out_load && done_found;

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            sel_data[i*WW +: WW] = entry_expected[done_id][i] ? entry_data[done_id][i] : '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int e = 0; e < NUM_ENTRIES; e++) begin
                entry_state[e]    <= ST_FREE;
                entry_expected[e] <= '0;
                entry_received[e] <= '0;
                entry_tag[e]      <= '0;
            end
            rr_ptr <= '0;
        end else begin
            for (int e = 0; e < NUM_ENTRIES; e++) begin
                if (entry_state[e] == ST_PENDING) begin
                    entry_received[e] <= entry_received[e] | entry_hits[e];
                    if ((entry_received[e] | entry_hits[e]) == entry_expected[e]) begin
                        entry_state[e] <= ST_DONE;
                    end
                end
                if (alloc_fire && free_id == e[IDW-1:0]) begin
                    entry_state[e]    <= (alloc_tmask == '0) ? ST_DONE : ST_PENDING;
                    entry_expected[e] <= alloc_tmask;
                    entry_received[e] <= '0;
                    entry_tag[e]      <= alloc_tag;
                end
                if (emit_fire && done_id == e[IDW-1:0]) begin
                    entry_state[e] <= ST_FREE;
                end
            end
            if (emit_fire) begin
                rr_ptr <= done_id + 1'b1;
            end
        end
    end

    // NOTE: the lane data array has no reset; a column is only read after the
    // lane has written it, and unexpected lanes are masked to zero on output.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQS; i++) begin
            if (lane_accept[i]) begin
                entry_data[lane_id[i]][i] <= lane_word[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid <= 1'b0;
            rsp_tmask <= '0;
            rsp_data  <= '0;
            rsp_tag   <= '0;
        end else if (out_load) begin
            rsp_valid <= done_found;
            if (done_found) begin
                rsp_tmask <= entry_expected[done_id];
                rsp_data  <= sel_data;
                rsp_tag   <= entry_tag[done_id];
            end
        end
    end

    // Dropped lane returns (duplicate, unexpected lane, or entry not PENDING) are flagged.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQS; i++) begin
                if (lane_rsp_valid[i]) begin
                    assert (lane_accept[i])
                        else $warning("lane %0d response to entry %0d dropped", i, lane_id[i]);
                end
            end
        end
    end

endmodule

// File: tb/tb_vx_dcache_rsp_collector.sv
// Bench for vx_dcache_rsp_collector: directed scenarios plus random traffic,
// all outputs compared each cycle against a table-of-requests reference model.
module tb_vx_dcache_rsp_collector;

    logic         clk;
    logic         reset;
    logic         alloc_valid;
    logic [3:0]   alloc_tmask;
    logic [7:0]   alloc_tag;
    logic         alloc_ready;
    logic [1:0]   alloc_id;
    logic [3:0]   lane_rsp_valid;
    logic [7:0]   lane_rsp_id;
    logic [127:0] lane_rsp_data;
    logic [3:0]   lane_rsp_ready;
    logic         rsp_valid;
    logic [3:0]   rsp_tmask;
    logic [127:0] rsp_data;
    logic [7:0]   rsp_tag;
    logic         rsp_ready;

    int vectors     = 0;
    int miscompares = 0;

    vx_dcache_rsp_collector dut (
        .clk            (clk),
        .reset          (reset),
        .alloc_valid    (alloc_valid),
        .alloc_tmask    (alloc_tmask),
        .alloc_tag      (alloc_tag),
        .alloc_ready    (alloc_ready),
        .alloc_id       (alloc_id),
        .lane_rsp_valid (lane_rsp_valid),
        .lane_rsp_id    (lane_rsp_id),
        .lane_rsp_data  (lane_rsp_data),
        .lane_rsp_ready (lane_rsp_ready),
        .rsp_valid      (rsp_valid),
        .rsp_tmask      (rsp_tmask),
        .rsp_data       (rsp_data),
        .rsp_tag        (rsp_tag),
        .rsp_ready      (rsp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a table of outstanding requests (0 idle, 1 waiting, 2 complete).
    int          m_st   [4];
    logic [3:0]  m_exp  [4];
    logic [3:0]  m_got  [4];
    logic [7:0]  m_tag  [4];
    logic [31:0] m_word [4][4];
    logic        m_ov;
    logic [3:0]  m_otm;
    logic [127:0] m_odata;
    logic [7:0]  m_otag;
    int          m_start;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int e = 0; e < 4; e++) begin
            m_st[e] = 0; m_exp[e] = '0; m_got[e] = '0; m_tag[e] = '0;
            for (int i = 0; i < 4; i++) m_word[e][i] = '0;
        end
        m_ov = 1'b0; m_otm = '0; m_odata = '0; m_otag = '0; m_start = 0;
    endtask

    function automatic int model_free_id();
        for (int e = 0; e < 4; e++) if (m_st[e] == 0) return e;
        return -1;
    endfunction

    task automatic model_step();
        int fid;
        int pick;
        int lid;
        fid  = model_free_id();
        pick = -1;
        if (!m_ov || rsp_ready) begin
            for (int j = 0; j < 4; j++) begin
                if (pick < 0 && m_st[(m_start + j) % 4] == 2) pick = (m_start + j) % 4;
            end
        end
        for (int i = 0; i < 4; i++) begin
            lid = int'(lane_rsp_id[i*2 +: 2]);
            if (lane_rsp_valid[i] && m_st[lid] == 1 && m_exp[lid][i] && !m_got[lid][i]) begin
                m_word[lid][i] = lane_rsp_data[i*32 +: 32];
                m_got[lid][i]  = 1'b1;
            end
        end
        for (int e = 0; e < 4; e++) if (m_st[e] == 1 && m_got[e] == m_exp[e]) m_st[e] = 2;
        if (!m_ov || rsp_ready) begin
            m_ov = (pick >= 0);
            if (pick >= 0) begin
                m_otm  = m_exp[pick];
                m_otag = m_tag[pick];
                for (int i = 0; i < 4; i++)
                    m_odata[i*32 +: 32] = m_exp[pick][i] ? m_word[pick][i] : 32'h0;
                m_st[pick] = 0;
                m_start    = (pick + 1) % 4;
            end
        end
        if (alloc_valid && fid >= 0) begin
            m_st[fid]  = (alloc_tmask == 4'h0) ? 2 : 1;
            m_exp[fid] = alloc_tmask;
            m_got[fid] = '0;
            m_tag[fid] = alloc_tag;
        end
    endtask

    // Inputs are set at the falling edge; compare, advance the model, then clock.
    task automatic cycle();
        int fid;
        #1;
        fid = model_free_id();
        check("alloc_ready", {127'h0, alloc_ready}, {127'h0, fid >= 0});
        if (fid >= 0) check("alloc_id", {126'h0, alloc_id}, 128'(fid));
        check("rsp_valid", {127'h0, rsp_valid}, {127'h0, m_ov});
        check("rsp_tmask", {124'h0, rsp_tmask}, {124'h0, m_otm});
        check("rsp_data", rsp_data, m_odata);
        check("rsp_tag", {120'h0, rsp_tag}, {120'h0, m_otag});
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        alloc_valid    = 1'b0;
        alloc_tmask    = '0;
        alloc_tag      = '0;
        lane_rsp_valid = '0;
    endtask

    task automatic do_alloc(input logic [3:0] tm, input logic [7:0] tg);
        alloc_valid = 1'b1;
        alloc_tmask = tm;
        alloc_tag   = tg;
    endtask

    task automatic drive_lane(input int lane, input int id, input logic [31:0] word);
        lane_rsp_valid[lane]        = 1'b1;
        lane_rsp_id[lane*2 +: 2]    = 2'(id);
        lane_rsp_data[lane*32 +: 32] = word;
    endtask

    // Random traffic; lane returns only target columns the model still owes.
    task automatic rand_inputs(input bit allow_alloc);
        int s;
        int e;
        idle();
        if (allow_alloc && $urandom_range(0, 2) == 0)
            do_alloc(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
        for (int i = 0; i < 4; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                s = $urandom_range(0, 3);
                for (int k = 0; k < 4; k++) begin
                    e = (s + k) % 4;
                    if (!lane_rsp_valid[i] && m_st[e] == 1 && m_exp[e][i] && !m_got[e][i])
                        drive_lane(i, e, $urandom);
                end
            end
        end
        rsp_ready = ($urandom_range(0, 3) != 0);
    endtask

    initial begin
        reset         = 1'b0;
        lane_rsp_id   = '0;
        lane_rsp_data = '0;
        rsp_ready     = 1'b1;
        idle();
        model_reset();

        // Held in reset
        #2;
        check("rst_alloc_ready", {127'h0, alloc_ready}, 128'h0);
        check("rst_rsp_valid", {127'h0, rsp_valid}, 128'h0);
        check("rst_rsp_tmask", {124'h0, rsp_tmask}, 128'h0);
        check("rst_rsp_data", rsp_data, 128'h0);
        check("rst_rsp_tag", {120'h0, rsp_tag}, 128'h0);
        check("lane_ready", {124'h0, lane_rsp_ready}, 128'hF);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("post_rst_ready", {127'h0, alloc_ready}, 128'h1);
        check("post_rst_id", {126'h0, alloc_id}, 128'h0);

        // Basic collection: lanes 0,1,3 in separate cycles
        do_alloc(4'b1011, 8'h5A);
        cycle();
        idle(); drive_lane(0, 0, 32'h11); cycle();
        idle(); drive_lane(1, 0, 32'h22); cycle();
        idle(); drive_lane(3, 0, 32'h44); cycle();
        check("basic_not_yet", {127'h0, rsp_valid}, 128'h0);
        idle(); cycle();
        check("basic_valid", {127'h0, rsp_valid}, 128'h1);
        check("basic_tmask", {124'h0, rsp_tmask}, 128'hB);
        check("basic_data", rsp_data, 128'h00000044_00000000_00000022_00000011);
        check("basic_tag", {120'h0, rsp_tag}, 128'h5A);
        cycle();

        // Fill the table, then complete entry 2 and watch it become allocatable
        for (int k = 0; k < 4; k++) begin
            do_alloc(4'(1 << k), 8'(8'hA0 + k));
            cycle();
        end
        idle();
        #1;
        check("full_ready", {127'h0, alloc_ready}, 128'h0);
        drive_lane(2, 2, 32'hC2); cycle();
        idle(); cycle();
        check("e2_valid", {127'h0, rsp_valid}, 128'h1);
        check("e2_tag", {120'h0, rsp_tag}, 128'hA2);
        check("e2_realloc_ready", {127'h0, alloc_ready}, 128'h1);
        check("e2_realloc_id", {126'h0, alloc_id}, 128'h2);

        // Entries 0 and 1 complete together while the output is stalled
        drive_lane(0, 0, 32'hD0); drive_lane(1, 1, 32'hD1); cycle();
        idle(); rsp_ready = 1'b0; cycle();
        for (int k = 0; k < 5; k++) begin
            check("stall_valid", {127'h0, rsp_valid}, 128'h1);
            check("stall_tag", {120'h0, rsp_tag}, 128'hA0);
            check("stall_data", rsp_data, 128'h000000D0);
            cycle();
        end
        rsp_ready = 1'b1; cycle();
        check("second_tag", {120'h0, rsp_tag}, 128'hA1);
        check("second_valid", {127'h0, rsp_valid}, 128'h1);
        cycle();
        check("drained_valid", {127'h0, rsp_valid}, 128'h0);
        drive_lane(3, 3, 32'hD3); cycle();
        idle(); cycle();
        check("e3_tag", {120'h0, rsp_tag}, 128'hA3);
        cycle();

        // Empty mask completes on allocation
        do_alloc(4'b0000, 8'h33); cycle();
        idle();
        check("zero_not_yet", {127'h0, rsp_valid}, 128'h0);
        cycle();
        check("zero_valid", {127'h0, rsp_valid}, 128'h1);
        check("zero_tmask", {124'h0, rsp_tmask}, 128'h0);
        check("zero_data", rsp_data, 128'h0);
        check("zero_tag", {120'h0, rsp_tag}, 128'h33);

        // Duplicate lane return and return to a free entry are dropped
        do_alloc(4'b0110, 8'h77);
        #1;
        check("dup_alloc_id", {126'h0, alloc_id}, 128'h0);
        cycle();
        idle(); drive_lane(2, 0, 32'hAAAA); cycle();
        idle(); drive_lane(2, 0, 32'hBBBB); drive_lane(0, 3, 32'hDEAD); cycle();
        check("dup_no_rsp", {127'h0, rsp_valid}, 128'h0);
        idle(); drive_lane(1, 0, 32'h1111); cycle();
        idle(); cycle();
        check("dup_valid", {127'h0, rsp_valid}, 128'h1);
        check("dup_tmask", {124'h0, rsp_tmask}, 128'h6);
        check("dup_data", rsp_data, 128'h00000000_0000AAAA_00001111_00000000);
        check("dup_tag", {120'h0, rsp_tag}, 128'h77);
        for (int k = 0; k < 3; k++) cycle();

        // Reset while work is pending and a response is held
        rsp_ready = 1'b0;
        do_alloc(4'b0000, 8'h35); cycle();
        do_alloc(4'b1111, 8'h36); cycle();
        do_alloc(4'b1111, 8'h37); cycle();
        idle();
        check("pre_rst_valid", {127'h0, rsp_valid}, 128'h1);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_valid", {127'h0, rsp_valid}, 128'h0);
        check("mid_rst_ready", {127'h0, alloc_ready}, 128'h0);
        model_reset();
        @(negedge clk);
        reset     = 1'b1;
        rsp_ready = 1'b1;
        #1;
        check("rel_ready", {127'h0, alloc_ready}, 128'h1);
        check("rel_id", {126'h0, alloc_id}, 128'h0);
        for (int k = 0; k < 5; k++) cycle();

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rand_inputs(1'b1);
            cycle();
        end
        for (int n = 0; n < 60; n++) begin
            rand_inputs(1'b0);
            rsp_ready = 1'b1;
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
